// File: rtl/robs_controller.sv
`default_nettype none
// ============================================================================
// Module      : robs_controller
// Description : Moore FSM sequencing a signed Robertson multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module robs_controller #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        zr,
  input  logic        zq,
  output logic [14:0] c,
  output logic        busy,
  output logic        done
);

  localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_INIT  = 4'd2,
    S_TEST  = 4'd3,
    S_ADD   = 4'd4,
    S_SUB   = 4'd5,
    S_SHIFT = 4'd6,
    S_LATCH = 4'd7,
    S_STORE = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic [c_IW-1:0]   r_iter;
  logic              w_iter_max;

  // Local iteration count backs up zq so a stuck counter flag cannot spin forever.
  assign w_iter_max = (r_iter == c_IW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_TEST)
        r_last <= zq | w_iter_max;
      if (r_state == S_LOAD)
        r_iter <= '0;
      else if (r_state == S_STORE)
        r_iter <= r_iter + c_IW'(1);
    end
  end

  always_comb begin
    w_next = S_IDLE;
    c      = 15'h0000;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy   = 1'b0;
        w_next = start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        c[3:0] = 4'b1111;
        w_next = S_INIT;
      end
      S_INIT: begin
        c[8]   = 1'b1;
        c[9]   = 1'b1;
        w_next = S_TEST;
      end
      S_TEST: begin
        if (zr)
          w_next = S_SHIFT;
        else if (zq)
          w_next = S_SUB;
        else
          w_next = S_ADD;
      end
      S_ADD: begin
        c[5:4] = 2'b10;
        c[10]  = 1'b1;
        c[8]   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SUB: begin
        c[5:4] = 2'b10;
        c[8]   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        c[12]  = 1'b1;
        c[11]  = 1'b1;
        w_next = S_LATCH;
      end
      S_LATCH: begin
        c[5:4] = 2'b01;
        c[6]   = 1'b1;
        c[8]   = 1'b1;
        c[9]   = 1'b1;
        w_next = S_STORE;
      end
      S_STORE: begin
        c[14]  = 1'b1;
        c[3]   = 1'b1;
        c[7]   = 1'b1;
        c[13]  = 1'b1;
        w_next = r_last ? S_DONE : S_INIT;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_robs_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_robs_controller
// Description : Bench driving robs_controller against a behavioural datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_robs_controller;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        zr, zq;
  logic [14:0] c;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  robs_controller #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .zr(zr), .zq(zq),
    .c(c), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: registers with signed integer arithmetic.
  logic signed [7:0] op_a = 8'sd0;
  logic signed [7:0] op_b = 8'sd0;
  int         m_A = 0, m_RH = 0, m_Y = 0, m_cnt = 0, m_Shi = 0;
  logic [7:0] m_X = 8'd0, m_RL = 8'd0, m_Slo = 8'd0;
  longint     w_sh;

  always_comb w_sh = (longint'(m_RH) * 256 + longint'(m_RL)) >>> 1;
  assign zr = ~m_RL[0];
  assign zq = (m_cnt == 0);

  always @(posedge clk) begin
    if (c[0]) m_Y <= int'(op_a);
    if (c[1]) m_cnt <= W - 1;
    else if (c[13]) m_cnt <= m_cnt - 1;
    if (c[2]) m_A <= 0;
    else if (c[14]) m_A <= m_RH;
    if (c[3]) m_X <= c[7] ? m_RL : op_b;
    if (c[8]) begin
      case (c[5:4])
        2'b00:   m_RH <= m_A;
        2'b01:   m_RH <= m_Shi;
        2'b10:   m_RH <= c[10] ? m_RH + m_Y : m_RH - m_Y;
        default: m_RH <= m_RH;
      endcase
    end
    if (c[9]) m_RL <= c[6] ? m_Slo : m_X;
    if (c[12]) begin
      m_Shi <= int'(w_sh >>> 8);
      m_Slo <= w_sh[7:0];
    end
  end

  function automatic logic [15:0] model_prod();
    logic [31:0] a32;
    a32 = m_A;
    return {a32[7:0], m_X};
  endfunction

  function automatic logic [15:0] ref_prod(logic [7:0] a, logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_alu(logic [14:0] cw);
    return cw[8] && (cw[5:4] == 2'b10);
  endfunction

  // One job: start sampled at edge 0; start re-pulsed at cycle pulse_at (0 = never).
  task automatic run_job(string tag, logic [7:0] a, logic [7:0] b, int pulse_at);
    int lat, dcnt, dcyc, adds, subs, sub_iter, stores;
    logic busy_after;
    lat = 2 + 5 * W + $countones(b);
    dcnt = 0; dcyc = -1; adds = 0; subs = 0; sub_iter = -1; stores = 0;
    busy_after = 1'bx;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat + 2; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_at);
      if (done) begin dcnt++; dcyc = cyc; end
      if (is_alu(c)) begin
        if (c[10]) adds++;
        else begin subs++; sub_iter = stores + 1; end
      end
      if (c[14]) stores++;
      if (cyc == lat + 1) busy_after = busy;
    end
    start = 1'b0;
    chk({tag, " done_count"}, dcnt, 1);
    chk({tag, " done_cycle"}, dcyc, lat);
    chk({tag, " busy_after"}, {31'd0, busy_after}, 32'd0);
    chk({tag, " product"}, {16'd0, model_prod()}, {16'd0, ref_prod(a, b)});
    chk({tag, " adds"}, adds, $countones(b[6:0]));
    chk({tag, " subs"}, subs, int'(b[7]));
    if (b[7]) chk({tag, " sub_iter"}, sub_iter, W);
  endtask

  initial begin
    int stores, d1, d2, l1, l2, lat;
    bit hit;
    logic [7:0] ra, rb;
    logic idle_busy;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst c", {17'd0, c}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    run_job("3x5", 8'd3, 8'd5, 0);
    run_job("7xm3", 8'd7, 8'hFD, 0);
    run_job("m128x0", 8'h80, 8'h00, 0);
    run_job("m128xm128", 8'h80, 8'h80, 0);

    // Reset during the 3rd iteration's ADD
    @(negedge clk);
    op_a = 8'd3; op_b = 8'd5; start = 1'b1;
    stores = 0; hit = 1'b0;
    for (int cyc = 1; cyc <= 60 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (is_alu(c) && c[10] && stores == 2) begin
        reset = 1'b0;
        hit = 1'b1;
      end
      if (c[14]) stores++;
    end
    chk("midrst reached_add3", {31'd0, hit}, 32'd1);
    @(negedge clk);
    chk("midrst c", {17'd0, c}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    run_job("post_rst 3x5", 8'd3, 8'd5, 0);

    // Start pulsed while busy must be ignored
    run_job("busy_start", 8'd9, 8'd11, 10);

    // Back-to-back jobs with start held high
    lat = 2 + 5 * W + $countones(8'h13);
    d1 = -1; d2 = -1; l1 = -1; l2 = -1; idle_busy = 1'bx;
    @(negedge clk);
    op_a = 8'hFA; op_b = 8'h13; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 2 * lat + 10 && d2 < 0; cyc++) begin
      @(negedge clk);
      if (c[3:0] == 4'hF && !c[7]) begin
        if (l1 < 0) l1 = cyc; else if (l2 < 0) l2 = cyc;
      end
      if (d1 >= 0 && cyc == d1 + 1) idle_busy = busy;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin d2 = cyc; start = 1'b0; end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b load1", l1, 1);
    chk("b2b done1", d1, lat);
    chk("b2b idle_gap", {31'd0, idle_busy}, 32'd0);
    chk("b2b load2", l2, d1 + 2);
    chk("b2b done2", d2, d1 + 1 + lat);
    chk("b2b product", {16'd0, model_prod()}, {16'd0, ref_prod(8'hFA, 8'h13)});
    chk("b2b final_busy", {31'd0, busy}, 32'd0);

    // Randomized operands
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_job("rand", ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
